// File: rtl/sigmoid_share_arbiter_if.sv
// Bundle between the neuron requesters, the sigmoid arbiter and the shared activation unit.
// The arbiter takes the slave view; requesters/activation unit take the master view.
interface sigmoid_share_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [DATA_WIDTH-1:0]         act_x;
  logic                          act_en;
  logic [DATA_WIDTH-1:0]         act_y;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, act_y, rsp_ready,
    output req_ready, act_x, act_en, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_data, act_y, rsp_ready,
    input  req_ready, act_x, act_en, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/sigmoid_share_arbiter.sv
// Round-robin share of one pipelined sigmoid unit among NUM_REQ requesters, with a tag
// pipeline matching the unit latency and a one-entry response buffer per requester.
module sigmoid_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACT_LATENCY = 3
) (
  input logic                   clk,
  input logic                   reset,
  sigmoid_share_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  typedef logic [IdxW-1:0] idx_t;

  logic [NUM_REQ-1:0]            pending_q, pending_d;
  logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_WIDTH-1:0]         act_x_q, act_x_d;
  logic                          act_en_q, act_en_d;
  idx_t                          ptr_q, ptr_d;
  logic [ACT_LATENCY-1:0]        tag_vld_q, tag_vld_d;
  idx_t                          tag_id_q [ACT_LATENCY];
  idx_t                          tag_id_d [ACT_LATENCY];

  logic [NUM_REQ-1:0] elig, grant, rsp_hs, rsp_wr;
  logic               grant_vld;
  idx_t               grant_idx;
  logic               res_vld;
  idx_t               res_id;

  // Search ptr, ptr+1, ... (mod NUM_REQ) for the first eligible requester.
  always_comb begin
    logic [IdxW:0] cand;
    elig      = bus.req_valid & ~pending_q;
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(off);
      if (cand >= (IdxW+1)'(NUM_REQ)) begin
        cand = cand - (IdxW+1)'(NUM_REQ);
      end
      if (!grant_vld && elig[cand[IdxW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IdxW-1:0];
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      if (grant_idx == idx_t'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + idx_t'(1);
      end
    end
  end

  always_comb begin
    act_en_d = grant_vld;
    act_x_d  = act_x_q;
    if (grant_vld) begin
      act_x_d = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Tag for an issue at edge E reaches the last stage so it is consumed at edge E+ACT_LATENCY.
  always_comb begin
    tag_vld_d[0] = grant_vld;
    tag_id_d[0]  = grant_idx;
    for (int unsigned k = 1; k < ACT_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  assign res_vld = tag_vld_q[ACT_LATENCY-1];
  assign res_id  = tag_id_q[ACT_LATENCY-1];

  always_comb begin
    rsp_hs     = rsp_valid_q & bus.rsp_ready;
    rsp_wr     = '0;
    rsp_data_d = rsp_data_q;
    if (res_vld) begin
      rsp_wr[res_id]                               = 1'b1;
      rsp_data_d[res_id*DATA_WIDTH +: DATA_WIDTH] = bus.act_y;
    end
    // A requester never has two operations outstanding, so set/clear never hit the same bit.
    pending_d   = (pending_q & ~rsp_hs) | grant;
    rsp_valid_d = (rsp_valid_q & ~rsp_hs) | rsp_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      act_x_q     <= '0;
      act_en_q    <= 1'b0;
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      for (int unsigned k = 0; k < ACT_LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      act_x_q     <= act_x_d;
      act_en_q    <= act_en_d;
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      for (int unsigned k = 0; k < ACT_LATENCY; k++) begin
        tag_id_q[k] <= tag_id_d[k];
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.act_x     = act_x_q;
  assign bus.act_en    = act_en_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = |pending_q;

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Directed bench for the sigmoid share arbiter at latency 3, plus a scoreboarded random
// sweep run on latency 1, 3 and 5 instances sharing the same request stimulus.
module tb_sigmoid_share_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [63:0]   req_data = '0;
  logic [NR-1:0] rsp_ready = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sigmoid_share_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if3 ();
  sigmoid_share_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if1 ();
  sigmoid_share_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if5 ();

  sigmoid_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACT_LATENCY(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.slave)
  );
  sigmoid_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACT_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );
  sigmoid_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACT_LATENCY(5)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (if5.slave)
  );

  assign if3.req_valid = req_valid;
  assign if1.req_valid = req_valid;
  assign if5.req_valid = req_valid;
  assign if3.req_data  = req_data;
  assign if1.req_data  = req_data;
  assign if5.req_data  = req_data;
  assign if3.rsp_ready = rsp_ready;
  assign if1.rsp_ready = rsp_ready;
  assign if5.rsp_ready = rsp_ready;

  // Index 0: latency 3, 1: latency 1, 2: latency 5.
  logic [NR-1:0] m_rr  [3];
  logic [NR-1:0] m_rsv [3];
  logic [63:0]   m_rsd [3];
  logic [15:0]   m_ax  [3];
  logic          m_busy[3];
  assign m_rr[0] = if3.req_ready;  assign m_rr[1] = if1.req_ready;  assign m_rr[2] = if5.req_ready;
  assign m_rsv[0] = if3.rsp_valid; assign m_rsv[1] = if1.rsp_valid; assign m_rsv[2] = if5.rsp_valid;
  assign m_rsd[0] = if3.rsp_data;  assign m_rsd[1] = if1.rsp_data;  assign m_rsd[2] = if5.rsp_data;
  assign m_ax[0] = if3.act_x;      assign m_ax[1] = if1.act_x;      assign m_ax[2] = if5.act_x;
  assign m_busy[0] = if3.busy;     assign m_busy[1] = if1.busy;     assign m_busy[2] = if5.busy;

  // Stand-in for the activation LUT; f(16'h0100) = 16'h00BB.
  function automatic logic [15:0] act_f(input logic [15:0] x);
    logic signed [15:0] s;
    s = $signed(x) >>> 2;
    return s ^ 16'h00FB;
  endfunction

  // Activation unit model: act_x history so act_y shows f(operand) ACT_LATENCY-1 edges on.
  logic [15:0] xh [3][8];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      xh[k][0] <= m_ax[k];
      for (int j = 1; j < 8; j++) xh[k][j] <= xh[k][j-1];
    end
  end
  assign if3.act_y = act_f(xh[0][1]);
  assign if1.act_y = act_f(m_ax[1]);
  assign if5.act_y = act_f(xh[2][3]);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    for (int n = 0; n < 10; n++) tick();
  endtask

  // Scoreboard state for the random sweep.
  int           lat [3] = '{3, 1, 5};
  int           cyc = 0;
  logic [NR-1:0] p_rr [3];
  logic [NR-1:0] p_rsv [3];
  logic [NR-1:0] p_rv, p_rrdy;
  logic [63:0]   p_data;
  logic          outst [3][NR];
  int            iss  [3][NR];
  logic [15:0]   expd [3][NR];

  task automatic sb_snap();
    for (int k = 0; k < 3; k++) begin
      p_rr[k]  = m_rr[k];
      p_rsv[k] = m_rsv[k];
    end
    p_rv   = req_valid;
    p_rrdy = rsp_ready;
    p_data = req_data;
  endtask

  // Called once per clock at the negedge: accounts for the edge since the last snapshot.
  task automatic sb_step();
    cyc++;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (p_rsv[k][i] && p_rrdy[i]) outst[k][i] = 1'b0;
        if (p_rr[k][i] && p_rv[i]) begin
          check_eq($sformatf("sb_single_L%0d_r%0d", lat[k], i), 64'(outst[k][i]), 64'd0);
          outst[k][i] = 1'b1;
          iss[k][i]   = cyc;
          expd[k][i]  = act_f(p_data[16*i +: 16]);
        end
        if (m_rsv[k][i] && !p_rsv[k][i]) begin
          check_eq($sformatf("sb_owner_L%0d_r%0d", lat[k], i), 64'(outst[k][i]), 64'd1);
          check_eq($sformatf("sb_lat_L%0d_r%0d", lat[k], i), 64'(cyc - iss[k][i]),
                   64'(lat[k]));
          check_eq($sformatf("sb_data_L%0d_r%0d", lat[k], i), 64'(m_rsd[k][16*i +: 16]),
                   64'(expd[k][i]));
        end else if (m_rsv[k][i]) begin
          check_eq($sformatf("sb_hold_L%0d_r%0d", lat[k], i), 64'(m_rsd[k][16*i +: 16]),
                   64'(expd[k][i]));
        end
      end
    end
    sb_snap();
  endtask

  // Test 2 tables, nibble k = cycle k.
  logic [39:0] rr_tab = 40'h0842108421;
  logic [39:0] rv_tab = 40'h2108421000;
  logic [9:0]  en_tab = 10'b0111101111;

  initial begin
    int cnt0;
    int cnt2;

    // Reset state and single requester.
    do_reset();
    check_eq("rst_req_ready", 64'(if3.req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(if3.rsp_valid), 64'd0);
    check_eq("rst_rsp_data", if3.rsp_data, 64'd0);
    check_eq("rst_act_en", 64'(if3.act_en), 64'd0);
    check_eq("rst_act_x", 64'(if3.act_x), 64'd0);
    check_eq("rst_busy", 64'(if3.busy), 64'd0);
    req_data[31:16] = 16'h0100;
    req_valid       = 4'b0010;
    #1;
    check_eq("t1_grant", 64'(if3.req_ready), 64'h2);
    tick();
    check_eq("t1_en_e0", 64'(if3.act_en), 64'd1);
    check_eq("t1_x_e0", 64'(if3.act_x), 64'h0100);
    check_eq("t1_busy", 64'(if3.busy), 64'd1);
    check_eq("t1_rr_pend", 64'(if3.req_ready), 64'd0);
    tick();
    check_eq("t1_en_e1", 64'(if3.act_en), 64'd0);
    check_eq("t1_x_hold", 64'(if3.act_x), 64'h0100);
    check_eq("t1_rsv_e1", 64'(if3.rsp_valid), 64'd0);
    tick();
    check_eq("t1_rsv_e2", 64'(if3.rsp_valid), 64'd0);
    tick();
    check_eq("t1_rsv_e3", 64'(if3.rsp_valid), 64'h2);
    check_eq("t1_rsd_e3", 64'(if3.rsp_data[31:16]), 64'h00BB);
    check_eq("t1_rr_e3", 64'(if3.req_ready), 64'd0);
    rsp_ready = 4'b0010;
    tick();
    check_eq("t1_rsv_hs", 64'(if3.rsp_valid), 64'd0);
    check_eq("t1_regrant", 64'(if3.req_ready), 64'h2);
    req_valid = '0;
    rsp_ready = '0;

    // All four requesting continuously.
    do_reset();
    req_data  = {16'h1000, 16'h0C00, 16'h0800, 16'h0400};
    rsp_ready = '1;
    req_valid = '1;
    #1;
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("t2_rr_c%0d", k), 64'(if3.req_ready), 64'(rr_tab[4*k +: 4]));
      tick();
      check_eq($sformatf("t2_en_c%0d", k), 64'(if3.act_en), 64'(en_tab[k]));
      check_eq($sformatf("t2_rsv_c%0d", k), 64'(if3.rsp_valid), 64'(rv_tab[4*k +: 4]));
      for (int j = 0; j < NR; j++) begin
        if (rv_tab[4*k+j]) begin
          check_eq($sformatf("t2_rsd_c%0d", k), 64'(if3.rsp_data[16*j +: 16]),
                   64'(act_f(req_data[16*j +: 16])));
        end
      end
    end
    drain();

    // Back-pressure on requester 2.
    do_reset();
    req_data  = {16'h0000, 16'hF800, 16'h0000, 16'h0321};
    req_valid = 4'b0101;
    rsp_ready = 4'b1011;
    cnt0      = 0;
    cnt2      = 0;
    #1;
    for (int k = 0; k < 14; k++) begin
      cnt0 += int'(if3.req_ready[0]);
      cnt2 += int'(if3.req_ready[2]);
      tick();
      if (k >= 4) begin
        check_eq($sformatf("t3_rsv2_c%0d", k), 64'(if3.rsp_valid[2]), 64'd1);
        check_eq($sformatf("t3_rsd2_c%0d", k), 64'(if3.rsp_data[47:32]),
                 64'(act_f(16'hF800)));
      end
    end
    check_eq("t3_grants0", 64'(cnt0), 64'd3);
    check_eq("t3_grants2", 64'(cnt2), 64'd1);
    rsp_ready = '1;
    #1;
    check_eq("t3_no_bypass", 64'(if3.req_ready), 64'd0);
    tick();
    check_eq("t3_regrant2", 64'(if3.req_ready), 64'h4);
    drain();

    // Fairness around the pointer.
    do_reset();
    rsp_ready = '1;
    req_valid = 4'b0100;
    #1;
    check_eq("t4_r2_p0", 64'(if3.req_ready), 64'h4);
    tick();
    req_valid = 4'b1001;
    #1;
    check_eq("t4_p3_first", 64'(if3.req_ready), 64'h8);
    tick();
    check_eq("t4_p3_second", 64'(if3.req_ready), 64'h1);
    tick();
    drain();
    check_eq("t4_idle", 64'(if3.busy), 64'd0);
    req_valid = 4'b0100;
    #1;
    check_eq("t4_r2_p1", 64'(if3.req_ready), 64'h4);
    tick();
    drain();
    req_valid = 4'b0100;
    #1;
    check_eq("t4_r2_p3", 64'(if3.req_ready), 64'h4);
    tick();
    req_valid = 4'b1011;
    #1;
    check_eq("t4_ptr_3", 64'(if3.req_ready), 64'h8);
    drain();

    // Reset with work in flight.
    do_reset();
    req_data  = {16'h0000, 16'h1234, 16'h5678, 16'h0ABC};
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0110;
    tick();
    tick();
    req_valid = '0;
    tick();
    check_eq("t5_pre_rsv", 64'(if3.rsp_valid), 64'h1);
    reset = 1'b1;
    tick();
    check_eq("t5_rr", 64'(if3.req_ready), 64'd0);
    check_eq("t5_en", 64'(if3.act_en), 64'd0);
    check_eq("t5_x", 64'(if3.act_x), 64'd0);
    check_eq("t5_rsv", 64'(if3.rsp_valid), 64'd0);
    check_eq("t5_rsd", if3.rsp_data, 64'd0);
    check_eq("t5_busy", 64'(if3.busy), 64'd0);
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check_eq($sformatf("t5_ghost_c%0d", n), 64'(if3.rsp_valid), 64'd0);
    end

    // Random sweep on all three latencies.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NR; i++) begin
        outst[k][i] = 1'b0;
        iss[k][i]   = 0;
        expd[k][i]  = '0;
      end
    end
    @(negedge clk);
    sb_snap();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      req_valid = NR'($urandom);
      req_data  = {$urandom, $urandom};
      rsp_ready = NR'($urandom);
      @(negedge clk);
      sb_step();
    end
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = '1;
      @(negedge clk);
      sb_step();
    end
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t6_busy_L%0d", lat[k]), 64'(m_busy[k]), 64'd0);
      for (int i = 0; i < NR; i++) begin
        check_eq($sformatf("t6_outst_L%0d_r%0d", lat[k], i), 64'(outst[k][i]), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sigmoid_share_arbiter.md
Name: sigmoid_share_arbiter

Overview:
Shares one pipelined sigmoid activation unit among NUM_REQ neuron requesters. It does three things:
- Round-robin arbitration of requests.
- Issues one operand per cycle to the activation unit and tracks in-flight tags through the unit's fixed latency.
- Returns each result to a per-requester one-entry response buffer with valid/ready handshake.

It sits between the neuron accumulators and the shared activation unit in the layer datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 16, operand/result width (signed fixed point; passed through unmodified)
ACT_LATENCY, 3, edges from the issue edge until act_y is sampled (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  one-hot grant; transfer on req_valid[i]&req_ready[i]
req_data  in  NUM_REQ*DATA_WIDTH  operand i at bits [i*DATA_WIDTH +: DATA_WIDTH]
act_x  out  DATA_WIDTH  registered operand to the activation unit
act_en  out  1  registered operand-valid to the activation unit (its c_en)
act_y  in  DATA_WIDTH  activation result, valid ACT_LATENCY edges after the issue edge
rsp_valid  out  NUM_REQ  result-valid per requester
rsp_ready  in  NUM_REQ  result-ready per requester
rsp_data  out  NUM_REQ*DATA_WIDTH  per-requester result buffer, same packing as req_data
busy  out  1  OR of all pending bits

Behaviour:
Reset:
- Clears ptr=0, pending=0, rsp_valid=0, rsp_data=0, act_en=0, act_x=0, all tag-pipeline valids=0, busy=0.
- A reset mid-operation discards every in-flight result. act_y values sampled while tags are invalid are ignored.

Eligibility and grant (combinational):
- elig[i] = req_valid[i] & ~pending[i].
- req_ready is one-hot on the first elig index found searching ptr, ptr+1, … mod NUM_REQ; all zero if none eligible.
- At most one grant per cycle.
- req_ready never depends on rsp_ready in the same cycle.

Accept edge (grant g):
- act_x <= req_data[g], act_en <= 1.
- pending[g] <= 1.
- ptr <= (g+1) mod NUM_REQ.
- Tag stage 0 <= {valid=1, id=g}.
- No grant: act_en <= 0, act_x holds its value, ptr holds, stage 0 valid <= 0.

Tag pipeline:
- Shift register of ACT_LATENCY-1 stages after stage 0, so the tag reaches the end at the issue edge + ACT_LATENCY.
- On that edge, if the tag is valid: rsp_data[id] <= act_y, rsp_valid[id] <= 1.
- Issue-to-rsp_valid latency is exactly ACT_LATENCY cycles. Throughput is one result per cycle across different requesters.

Response handshake:
- rsp_valid[i] & rsp_ready[i] at an edge clears rsp_valid[i] and pending[i].
- rsp_data[i] holds its value while rsp_valid[i] is high.

Outstanding limit:
- Each requester has at most one operation outstanding, in flight or buffered. Consequently a result write can never collide with an unconsumed rsp_valid for the same id.

Simultaneous events:
- pending[i] cleared and req_valid[i] high in the same cycle: requester i becomes eligible only in the following cycle (no bypass).
- A result write to id i and a response handshake on a different id at the same edge: both take effect.

No flow control toward the activation unit: it is assumed to accept one operand per cycle.

Test Plan:
1. Single requester: ACT_LATENCY=3; req_valid[1]=1, req_data[1]=16'h0100 accepted at edge E0; model returns act_y=16'h00BB sampled at E3. Required: act_en high for exactly one cycle after E0; rsp_valid[1] high after E3 with rsp_data[1]=16'h00BB; req_ready[1]=0 until the handshake completes.
2. All four request continuously, rsp_ready=4'hF, ptr=0: grants in order 0,1,2,3; act_en high for 4 consecutive cycles; rsp_valid asserts 0,1,2,3 on consecutive cycles; each requester is re-granted only the cycle after its response handshake.
3. Back-pressure: rsp_ready[2]=0 for 10 cycles while requesters 0 and 2 are requesting. Required: requester 2 granted once, rsp_valid[2] and rsp_data[2] stable for all 10 cycles, requester 0 keeps cycling; after rsp_ready[2]=1, requester 2 is eligible again one cycle later.
4. Fairness: ptr=3; requesters 0 and 3 both eligible → grant 3, then 0. Requester 2 alone eligible with ptr=3 → grant 2, and ptr becomes 3.
5. Reset mid-flight: two operations in the tag pipeline and rsp_valid[0]=1; assert reset for one edge. Required: all outputs zero after that edge, and no rsp_valid asserts from the discarded operations in the following ACT_LATENCY cycles.
6. Latency sweep with ACT_LATENCY=1 and 5: random requests and ready signals. Scoreboard checks every result matches sigmoid(req_data) for the correct id and that issue-to-rsp_valid latency equals ACT_LATENCY.
